rs232_receiver: RTL

Serial-to-parallel RS232 receiver for the Root_calculator UART link; the counterpart of the existing RS232 transmitter on the same line format (8 data bits, LSB first, 1 start, 1 stop, idle high). Synchronises the asynchronous `rx` pin and detects the start edge. Samples each bit at mid-bit using a clock-cycle counter, then presents each received byte on `data` with a one-cycle `data_valid` strobe. Feeds the command/operand parser upstream of the root computation core.

---
 rtl/rs232_pkg.sv | 16 +
 rtl/rs232_bit_timer.sv | 37 +++
 rtl/rs232_receiver.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared RS232 line-format definitions for the receiver and transmitter.
// Frame: 1 start, DATA_BITS data (LSB first), 1 stop, idle high.
package rs232_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic RS232_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/rs232_bit_timer.sv
// Loadable down-counter giving one tick per loaded interval.
// tick is high in the last cycle of the interval; load wins over counting.
module rs232_bit_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/rs232_receiver.sv
// RS232 receiver: 2-FF synchroniser, mid-bit sampling, byte strobe.
// Define RS232_PARITY_EN to add an even-parity bit and parity_error.
module rs232_receiver
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
`ifdef RS232_PARITY_EN
  ,
  output logic       parity_error
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT + 1);
`ifdef RS232_PARITY_EN
  localparam int NBITS = DATA_BITS + 1;
`else
  localparam int NBITS = DATA_BITS;
`endif
  localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);

  rx_state_e state_q, state_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic dv_q, dv_d;
  logic fe_q, fe_d;
  logic sync1_q, rx_s_q;
  logic load;
  logic [TW-1:0] load_val;
  logic tick;
`ifdef RS232_PARITY_EN
  logic par_q, par_d;
  logic pe_q, pe_d;
`endif

  rs232_bit_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .tick    (tick)
  );

  // Two-flop synchroniser for the asynchronous rx pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RS232_IDLE;
      rx_s_q  <= RS232_IDLE;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Frame FSM: next state, shift register and output strobes.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    fe_d     = 1'b0;
    load     = 1'b0;
    load_val = TW'(CLKS_PER_BIT);
`ifdef RS232_PARITY_EN
    par_d    = par_q;
    pe_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_s_q != RS232_IDLE) begin
          state_d  = START;
          bit_d    = '0;
          load     = 1'b1;
          load_val = TW'(HALF_BIT);
        end
      end
      START: begin
        if (tick) begin
          load    = 1'b1;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          load  = 1'b1;
          bit_d = bit_q + 4'd1;
`ifdef RS232_PARITY_EN
          if (bit_q == LAST_BIT) begin
            par_d = rx_s_q;
          end else begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          end
`else
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
`endif
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
`ifdef RS232_PARITY_EN
            pe_d    = par_q != (^shift_q);
`endif
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef RS232_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef RS232_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign data          = data_q;
  assign data_valid    = dv_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != IDLE);
`ifdef RS232_PARITY_EN
  assign parity_error  = pe_q;
`endif

endmodule
